// File: rtl/video_raster_pkg.sv
// Shared types, constants and colour expansion for the video raster capture block.
package video_raster_pkg;

  typedef logic [1:0] state_t;

  localparam state_t SEARCH = 2'd0;
  localparam state_t VBLANK = 2'd1;
  localparam state_t ACTIVE = 2'd2;
  localparam state_t HBLANK = 2'd3;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  // Widen a colour channel by repeating its bits MSB-first; e.g. 3'b101 -> 8'b1011_0110.
  function automatic logic [31:0] expand_color(input logic [31:0] c,
                                               input int unsigned in_bits,
                                               input int unsigned out_bits);
    logic [31:0] res;
    res = '0;
    for (int unsigned i = 0; i < out_bits; i++) begin
      res[out_bits-1-i] = c[in_bits-1-(i%in_bits)];
    end
    return res;
  endfunction

endpackage

// File: rtl/video_crc32_update.sv
// Combinational CRC-32 step (poly 0x04C11DB7) over DATA_W data bits, consumed MSB first.
module video_crc32_update
  import video_raster_pkg::*;
#(
  parameter int unsigned DATA_W = 24
) (
  input  logic [31:0]       crc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [31:0]       crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i;
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      if (c[31] ^ data_i[i]) begin
        c = {c[30:0], 1'b0} ^ CRC32_POLY;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    crc_o = c;
  end

endmodule

// File: rtl/video_raster_capture.sv
// Raster tracker: recovers pixel x/y and line/frame boundaries from pixel CEN and video enable.
// Define VIDEO_RASTER_CRC_EN to add a per-frame CRC-32 signature on o_FRAME_CRC.
module video_raster_capture
  import video_raster_pkg::*;
#(
  parameter int unsigned COLOR_BITS = 3,
  parameter int unsigned OUT_BITS   = 8,
  parameter int unsigned H_ACTIVE   = 256,
  parameter int unsigned V_ACTIVE   = 224,
  parameter int unsigned V_GAP_MIN  = 64
) (
  input  logic                          i_EMU_MCLK,
  input  logic                          i_EMU_INITRST_n,
  input  logic                          i_VIDEO_CEN,
  input  logic                          i_VIDEO_EN,
  input  logic [COLOR_BITS-1:0]         i_VIDEO_R,
  input  logic [COLOR_BITS-1:0]         i_VIDEO_G,
  input  logic [COLOR_BITS-1:0]         i_VIDEO_B,
  output logic                          o_PX_VALID,
  output logic [$clog2(2*H_ACTIVE)-1:0] o_PX_X,
  output logic [$clog2(2*V_ACTIVE)-1:0] o_PX_Y,
  output logic [OUT_BITS-1:0]           o_PX_R,
  output logic [OUT_BITS-1:0]           o_PX_G,
  output logic [OUT_BITS-1:0]           o_PX_B,
  output logic                          o_SOF,
  output logic                          o_SOL,
  output logic                          o_EOF,
  output logic                          o_LINE_ERR,
  output logic                          o_FRAME_ERR,
  output logic [$clog2(2*V_ACTIVE)-1:0] o_LINE_COUNT,
  output logic [15:0]                   o_FRAME_CNT,
  output logic [31:0]                   o_FRAME_CRC
);

  localparam int unsigned XW = $clog2(2*H_ACTIVE);
  localparam int unsigned YW = $clog2(2*V_ACTIVE);
  localparam int unsigned RW = $clog2(V_GAP_MIN+1);

  state_t              state_q, state_d;
  logic [RW-1:0]       run_q, run_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [OUT_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                valid_q, valid_d, sof_q, sof_d, sol_q, sol_d;
  logic                eof_q, eof_d, line_err_q, line_err_d;
  logic                acc_err_q, acc_err_d, frame_err_q, frame_err_d;
  logic [YW-1:0]       line_count_q, line_count_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;

  logic [OUT_BITS-1:0] r_exp, g_exp, b_exp;
  logic                x_max, y_max, line_bad, lines_bad, gap_hit;
  logic [XW-1:0]       x_inc;
  logic [YW-1:0]       y_inc;
  logic [RW-1:0]       run_inc;

  assign r_exp = OUT_BITS'(expand_color(32'(i_VIDEO_R), COLOR_BITS, OUT_BITS));
  assign g_exp = OUT_BITS'(expand_color(32'(i_VIDEO_G), COLOR_BITS, OUT_BITS));
  assign b_exp = OUT_BITS'(expand_color(32'(i_VIDEO_B), COLOR_BITS, OUT_BITS));

  assign x_max     = (x_q == '1);
  assign y_max     = (y_q == '1);
  assign x_inc     = x_max ? x_q : x_q + XW'(1);
  assign y_inc     = y_max ? y_q : y_q + YW'(1);
  assign run_inc   = (run_q == '1) ? run_q : run_q + RW'(1);
  assign gap_hit   = (32'(run_inc) >= V_GAP_MIN);
  // x/y hold the index of the last pixel/line, so the count is one more.
  assign line_bad  = (({1'b0, x_q} + (XW+1)'(1)) != (XW+1)'(H_ACTIVE));
  assign lines_bad = (({1'b0, y_q} + (YW+1)'(1)) != (YW+1)'(V_ACTIVE));

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    x_d          = x_q;
    y_d          = y_q;
    r_d          = r_q;
    g_d          = g_q;
    b_d          = b_q;
    valid_d      = 1'b0;
    sof_d        = 1'b0;
    sol_d        = 1'b0;
    eof_d        = 1'b0;
    line_err_d   = 1'b0;
    acc_err_d    = acc_err_q;
    frame_err_d  = frame_err_q;
    line_count_d = line_count_q;
    frame_cnt_d  = frame_cnt_q;

    if (i_VIDEO_CEN) begin
      if (i_VIDEO_EN && state_q != SEARCH) begin
        r_d = r_exp;
        g_d = g_exp;
        b_d = b_exp;
      end
      case (state_q)
        SEARCH: begin
          if (i_VIDEO_EN) begin
            run_d = '0;
          end else begin
            run_d = run_inc;
            if (gap_hit) state_d = VBLANK;
          end
        end
        VBLANK: begin
          if (i_VIDEO_EN) begin
            state_d   = ACTIVE;
            valid_d   = 1'b1;
            sof_d     = 1'b1;
            sol_d     = 1'b1;
            x_d       = '0;
            y_d       = '0;
            acc_err_d = 1'b0;
          end
        end
        ACTIVE: begin
          if (i_VIDEO_EN) begin
            valid_d = 1'b1;
            x_d     = x_inc;
            if (x_max) acc_err_d = 1'b1;
          end else begin
            state_d = HBLANK;
            run_d   = RW'(1);
            if (line_bad) begin
              line_err_d = 1'b1;
              acc_err_d  = 1'b1;
            end
          end
        end
        default: begin
          if (i_VIDEO_EN) begin
            state_d = ACTIVE;
            valid_d = 1'b1;
            sol_d   = 1'b1;
            x_d     = '0;
            y_d     = y_inc;
            if (y_max) acc_err_d = 1'b1;
          end else begin
            run_d = run_inc;
            if (gap_hit) begin
              state_d      = VBLANK;
              eof_d        = 1'b1;
              line_count_d = y_inc;
              frame_err_d  = acc_err_q | lines_bad;
              frame_cnt_d  = frame_cnt_q + 16'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      state_q      <= SEARCH;
      run_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      valid_q      <= 1'b0;
      sof_q        <= 1'b0;
      sol_q        <= 1'b0;
      eof_q        <= 1'b0;
      line_err_q   <= 1'b0;
      acc_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      line_count_q <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      x_q          <= x_d;
      y_q          <= y_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      valid_q      <= valid_d;
      sof_q        <= sof_d;
      sol_q        <= sol_d;
      eof_q        <= eof_d;
      line_err_q   <= line_err_d;
      acc_err_q    <= acc_err_d;
      frame_err_q  <= frame_err_d;
      line_count_q <= line_count_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign o_PX_VALID   = valid_q;
  assign o_PX_X       = x_q;
  assign o_PX_Y       = y_q;
  assign o_PX_R       = r_q;
  assign o_PX_G       = g_q;
  assign o_PX_B       = b_q;
  assign o_SOF        = sof_q;
  assign o_SOL        = sol_q;
  assign o_EOF        = eof_q;
  assign o_LINE_ERR   = line_err_q;
  assign o_FRAME_ERR  = frame_err_q;
  assign o_LINE_COUNT = line_count_q;
  assign o_FRAME_CNT  = frame_cnt_q;

`ifdef VIDEO_RASTER_CRC_EN
  logic [31:0] crc_q, crc_d, crc_seed, crc_next, frame_crc_q, frame_crc_d;

  // The SOF pixel restarts the signature from the init value.
  assign crc_seed = (state_q == VBLANK) ? CRC32_INIT : crc_q;

  video_crc32_update #(
    .DATA_W(3*OUT_BITS)
  ) u_crc (
    .crc_i (crc_seed),
    .data_i({r_exp, g_exp, b_exp}),
    .crc_o (crc_next)
  );

  always_comb begin
    crc_d       = crc_q;
    frame_crc_d = frame_crc_q;
    if (valid_d) crc_d = crc_next;
    if (eof_d) frame_crc_d = ~crc_q;
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      crc_q       <= '0;
      frame_crc_q <= '0;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign o_FRAME_CRC = frame_crc_q;
`else
  assign o_FRAME_CRC = '0;
`endif

endmodule

// File: tb/tb_video_raster_capture.sv
// Scoreboard bench for video_raster_capture on a reduced 16x12 raster (gap 10 ticks).
module tb_video_raster_capture;

  localparam int H   = 16;
  localparam int V   = 12;
  localparam int G   = 10;
  localparam int HBL = 4;
  localparam int XW  = $clog2(2*H);
  localparam int YW  = $clog2(2*V);
`ifdef VIDEO_RASTER_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
    logic          sof;
    logic          sol;
    logic [31:0]   cyc;
  } pix_t;

  typedef struct packed {
    logic [YW-1:0] lc;
    logic          ferr;
    logic [15:0]   fcnt;
    logic [31:0]   crc;
    logic [31:0]   cyc;
  } eof_t;

  logic clk = 1'b0;
  logic rst_n;
  logic cen, en_i;
  logic [2:0] vr, vg, vb;
  logic o_PX_VALID, o_SOF, o_SOL, o_EOF, o_LINE_ERR, o_FRAME_ERR;
  logic [XW-1:0] o_PX_X;
  logic [YW-1:0] o_PX_Y, o_LINE_COUNT;
  logic [7:0] o_PX_R, o_PX_G, o_PX_B;
  logic [15:0] o_FRAME_CNT;
  logic [31:0] o_FRAME_CRC;

  logic [31:0] cyc = '0;
  int n_chk = 0;
  int n_pass = 0;
  int exp_fcnt = 0;
  pix_t exp_pix[$];
  eof_t exp_eof[$];
  logic [31:0] exp_lerr[$];
  logic [31:0] crc_obs[16];
  pix_t ep;
  eof_t ee;
  logic [31:0] el;

  // Hand-expanded 3-bit -> 8-bit colour values.
  logic [7:0] exp3[8] = '{8'h00, 8'h24, 8'h49, 8'h6D, 8'h92, 8'hB6, 8'hDB, 8'hFF};

  video_raster_capture #(
    .COLOR_BITS(3),
    .OUT_BITS  (8),
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .V_GAP_MIN (G)
  ) dut (
    .i_EMU_MCLK     (clk),
    .i_EMU_INITRST_n(rst_n),
    .i_VIDEO_CEN    (cen),
    .i_VIDEO_EN     (en_i),
    .i_VIDEO_R      (vr),
    .i_VIDEO_G      (vg),
    .i_VIDEO_B      (vb),
    .o_PX_VALID     (o_PX_VALID),
    .o_PX_X         (o_PX_X),
    .o_PX_Y         (o_PX_Y),
    .o_PX_R         (o_PX_R),
    .o_PX_G         (o_PX_G),
    .o_PX_B         (o_PX_B),
    .o_SOF          (o_SOF),
    .o_SOL          (o_SOL),
    .o_EOF          (o_EOF),
    .o_LINE_ERR     (o_LINE_ERR),
    .o_FRAME_ERR    (o_FRAME_ERR),
    .o_LINE_COUNT   (o_LINE_COUNT),
    .o_FRAME_CNT    (o_FRAME_CNT),
    .o_FRAME_CRC    (o_FRAME_CRC)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // CRC-32 reference, byte at a time, MSB first.
  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [23:0] d);
    logic [31:0] x;
    x = c;
    for (int k = 2; k >= 0; k--) begin
      x = x ^ {d[k*8 +: 8], 24'h0};
      for (int j = 0; j < 8; j++) x = x[31] ? ((x << 1) ^ 32'h04C11DB7) : (x << 1);
    end
    return x;
  endfunction

  function automatic logic [8:0] pix_color(input int x, input int y, input int mode);
    logic [2:0] r, g, b;
    if (mode == 0) return 9'h0;
    r = 3'((x + y) % 8);
    g = 3'(x % 8);
    b = 3'(y % 8);
    if (x == 0 && y == 0) begin
      r = 3'b101;
      g = 3'b111;
      b = 3'b000;
    end
    if (mode == 2 && x == 3 && y == 2) r = ~r;
    return {r, g, b};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cen  = 1'b0;
      en_i = 1'($urandom);
      vr   = 3'($urandom);
      vg   = 3'($urandom);
      vb   = 3'($urandom);
    end
  endtask

  task automatic drive(input logic en, input logic [8:0] c);
    if ($urandom_range(0, 3) == 0) idle(1);
    @(negedge clk);
    cen  = 1'b1;
    en_i = en;
    {vr, vg, vb} = c;
  endtask

  task automatic send_pixel(input int x, input int y, input logic [8:0] c, input logic sof);
    pix_t e;
    drive(1'b1, c);
    e.x   = XW'(x);
    e.y   = YW'(y);
    e.r   = exp3[c[8:6]];
    e.g   = exp3[c[5:3]];
    e.b   = exp3[c[2:0]];
    e.sof = sof;
    e.sol = (x == 0);
    e.cyc = cyc + 32'd1;
    exp_pix.push_back(e);
  endtask

  task automatic send_blank(input logic lerr, input logic eof, input int lc, input logic ferr,
                            input logic [31:0] crc);
    eof_t e;
    drive(1'b0, 9'($urandom));
    if (lerr) exp_lerr.push_back(cyc + 32'd1);
    if (eof) begin
      e.lc   = YW'(lc);
      e.ferr = ferr;
      e.fcnt = 16'(exp_fcnt);
      e.crc  = CRC_ON ? ~crc : 32'h0;
      e.cyc  = cyc + 32'd1;
      exp_eof.push_back(e);
    end
  endtask

  task automatic send_frame(input int nlines, input int mode, input int short_y, input int gap_y,
                            input int stall_y, input logic ferr);
    logic [31:0] crc;
    logic [8:0]  c;
    int len, hb;
    crc = 32'hFFFFFFFF;
    exp_fcnt++;
    for (int y = 0; y < nlines; y++) begin
      len = (y == short_y) ? H - 1 : H;
      for (int x = 0; x < len; x++) begin
        c = pix_color(x, y, mode);
        crc = crc_ref(crc, {exp3[c[8:6]], exp3[c[5:3]], exp3[c[2:0]]});
        send_pixel(x, y, c, (x == 0 && y == 0));
        if (y == stall_y && x == 7) begin
          idle(1000);
          chk("stall_x_hold", 32'(o_PX_X), 32'd7);
          chk("stall_y_hold", 32'(o_PX_Y), 32'(y));
        end
      end
      hb = (y == nlines - 1) ? G : ((y == gap_y) ? G - 1 : HBL);
      for (int k = 0; k < hb; k++) begin
        send_blank((k == 0) && (len != H), (y == nlines - 1) && (k == G - 1), nlines, ferr, crc);
      end
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_PX_VALID) begin
          if (exp_pix.size() == 0) begin
            chk("px_unexpected", 32'(o_PX_VALID), 32'd0);
          end else begin
            ep = exp_pix.pop_front();
            chk("px_cycle", cyc, ep.cyc);
            chk("px_x", 32'(o_PX_X), 32'(ep.x));
            chk("px_y", 32'(o_PX_Y), 32'(ep.y));
            chk("px_rgb", {8'h0, o_PX_R, o_PX_G, o_PX_B}, {8'h0, ep.r, ep.g, ep.b});
            chk("px_sof", 32'(o_SOF), 32'(ep.sof));
            chk("px_sol", 32'(o_SOL), 32'(ep.sol));
          end
        end else if (o_SOF || o_SOL) begin
          chk("sof_sol_without_valid", 32'(o_PX_VALID), 32'd1);
        end
        if (o_EOF) begin
          if (exp_eof.size() == 0) begin
            chk("eof_unexpected", 32'(o_EOF), 32'd0);
          end else begin
            ee = exp_eof.pop_front();
            chk("eof_cycle", cyc, ee.cyc);
            chk("eof_line_count", 32'(o_LINE_COUNT), 32'(ee.lc));
            chk("eof_frame_err", 32'(o_FRAME_ERR), 32'(ee.ferr));
            chk("eof_frame_cnt", 32'(o_FRAME_CNT), 32'(ee.fcnt));
            chk("eof_frame_crc", o_FRAME_CRC, ee.crc);
            crc_obs[o_FRAME_CNT[3:0]] = o_FRAME_CRC;
          end
        end
        if (o_LINE_ERR) begin
          if (exp_lerr.size() == 0) begin
            chk("line_err_unexpected", 32'(o_LINE_ERR), 32'd0);
          end else begin
            el = exp_lerr.pop_front();
            chk("line_err_cycle", cyc, el);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    cen   = 1'b0;
    en_i  = 1'b0;
    vr    = '0;
    vg    = '0;
    vb    = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(o_PX_VALID), 32'd0);
    chk("rst_x", 32'(o_PX_X), 32'd0);
    chk("rst_frame_cnt", 32'(o_FRAME_CNT), 32'd0);
    chk("rst_line_count", 32'(o_LINE_COUNT), 32'd0);
    chk("rst_frame_err", 32'(o_FRAME_ERR), 32'd0);
    chk("rst_frame_crc", o_FRAME_CRC, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Reach VBLANK, start a frame, then reset mid-line.
    for (int k = 0; k < 12; k++) send_blank(1'b0, 1'b0, 0, 1'b0, 32'h0);
    for (int x = 0; x < 3; x++) send_pixel(x, 0, pix_color(x, 0, 1), (x == 0));
    idle(3);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_x", 32'(o_PX_X), 32'd0);
    chk("midrst_valid", 32'(o_PX_VALID), 32'd0);
    chk("midrst_rgb", {8'h0, o_PX_R, o_PX_G, o_PX_B}, 32'd0);
    rst_n = 1'b1;

    // Active video while searching must produce nothing.
    for (int k = 0; k < 5; k++) drive(1'b1, 9'($urandom));
    for (int k = 0; k < 100; k++) send_blank(1'b0, 1'b0, 0, 1'b0, 32'h0);

    send_frame(V, 1, -1, -1, -1, 1'b0);
    send_frame(V, 1, -1, -1, -1, 1'b0);
    send_frame(V, 2, -1, -1, -1, 1'b0);
    send_frame(V, 1, 10, -1, -1, 1'b1);
    send_frame(V, 1, -1, -1, -1, 1'b0);
    send_frame(V + 1, 1, -1, -1, -1, 1'b1);
    send_frame(V, 0, -1, 5, 3, 1'b0);
    idle(20);

    chk("final_frame_cnt", 32'(o_FRAME_CNT), 32'd7);
    chk("pix_queue_drained", 32'(exp_pix.size()), 32'd0);
    chk("eof_queue_drained", 32'(exp_eof.size()), 32'd0);
    chk("line_err_queue_drained", 32'(exp_lerr.size()), 32'd0);
`ifdef VIDEO_RASTER_CRC_EN
    chk("crc_repeat_frame", crc_obs[2], crc_obs[1]);
    chk("crc_poked_differs", 32'(crc_obs[3] != crc_obs[1]), 32'd1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
